bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single daisy-chained register bus (lut_mem chain terminating in bridge_tx) between two requesters.
  - Requester A: bridge_rx.
  - Requester B: an on-chip host.
- Arbitrates round-robin and issues one request per cycle onto the chain head.
- Tracks which requester owns each in-flight transaction and steers each response from the chain tail back to its owner.
- Responses return in issue order. An ID FIFO of depth MAX_OUTSTANDING does the routing.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- MAX_OUTSTANDING, 8, maximum in-flight transactions. Must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- a_addr  in  ADDR_WIDTH  requester A address
- a_wdata  in  DATA_WIDTH  requester A write data
- a_rw  in  1  requester A direction, 1 = write
- a_valid  in  1  requester A request valid
- a_ready  out  1  requester A request accepted this cycle
- a_res_data  out  DATA_WIDTH  response data to A
- a_res_valid  out  1  response strobe to A
- b_addr, b_wdata, b_rw, b_valid, b_ready, b_res_data, b_res_valid: same as the A ports, for requester B
- addr_o  out  ADDR_WIDTH  chain head address
- wdata_o  out  DATA_WIDTH  chain head write data
- rdata_o  out  DATA_WIDTH  chain head read data, tied 0
- rw_o  out  1  chain head direction
- valid_o  out  1  chain head valid
- rdata_i  in  DATA_WIDTH  chain tail read data
- valid_i  in  1  chain tail valid, one beat per issued request, reads and writes alike
- busy  out  1  outstanding count != 0
- err  out  1  sticky: a response arrived with no outstanding entry

Behaviour:
- Reset (rst == 0 at a clk edge):
  - All outputs are 0 and the ID FIFO is emptied.
  - last_grant is set to B, so A wins the first tie.
  - err is cleared. err is cleared only by reset.
- Space:
  - space = (count < MAX_OUTSTANDING) OR valid_i.
  - A simultaneous pop frees the slot in the same cycle.
- Grant (combinational, same cycle):
  - Only one requester valid and space: grant it.
  - Both valid and space: grant the one that is not last_grant.
  - x_ready = granted requester and space. It is asserted only while x_valid is high.
- Requester rules:
  - A requester holds valid, addr, wdata and rw stable until ready.
  - The arbiter never drops a held request.
  - No starvation: under continuous contention, grants alternate A, B, A, B.
- Issue:
  - A grant at edge N registers addr, wdata and rw onto the bus outputs, with valid_o = 1 during cycle N+1.
  - valid_o = 0 in every cycle without a grant.
  - Back-to-back grants produce back-to-back valid_o beats.
- ID FIFO:
  - On grant, push the requester ID (0 = A, 1 = B).
  - On valid_i, pop the head ID.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - count has width clog2(MAX_OUTSTANDING)+1.
- Response routing:
  - valid_i at edge M with head ID = A gives a_res_valid = 1 and a_res_data = rdata_i during cycle M+1 (registered, 1-cycle latency).
  - Head ID = B behaves the same on the b_res ports.
  - The non-selected res_valid is 0. Its res_data holds its last value.
- Empty pop:
  - valid_i with count == 0: the response is dropped and no res_valid is asserted.
  - err is set and count stays 0.
  - This covers chain beats still in flight across a mid-operation reset.
- Full:
  - count == MAX_OUTSTANDING and no valid_i: both readys are 0 and the requests wait.
- Reset mid-operation: pending grants are abandoned, and requesters must re-present.
- Latency, idle bus: request to valid_o is 1 cycle. valid_i to res_valid is 1 cycle. End-to-end latency is chain latency + 2.

Test Plan:
- Single read: 3-stage lut_mem chain, A requests read addr 0x0001 -> valid_o one cycle later with addr_o = 0x0001, rw_o = 0, a_ready high for exactly 1 cycle -> a_res_valid with a_res_data = 0x0001 (mem_1 preloaded 0x0000..0x0007), b_res_valid stays 0.
- Contention: A reads 0x0009 and B reads 0x0012, both valid from the same cycle -> A issued first, B next cycle -> a_res_data = 0x0009 then b_res_data = 0x0012 on consecutive cycles.
- Fairness: A and B both hold valid for 8 requests -> grant order A,B,A,B,A,B,A,B -> each gets 4 responses routed correctly.
- Full: MAX_OUTSTANDING = 8 with valid_i forced 0 and B streaming -> 8 grants then b_ready = 0 -> one valid_i pulse -> b_ready high in that same cycle, count stays 8.
- Write then read: B writes 0xBEEF to 0x0014 then reads 0x0014 -> two responses to B, second has b_res_data = 0xBEEF.
- Reset mid-flight: 3 reads issued, rst low 1 cycle, chain beats still arrive -> no res_valid, err = 1, busy = 0. Next A read completes normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Shares one daisy-chained register bus between requester A (bridge_rx) and
// requester B (on-chip host). Requests are granted round-robin, at most one
// per cycle, and registered onto the chain head. The owner of each in-flight
// transaction is remembered in an in-order ID FIFO. Each beat returning from
// the chain tail is steered back to its owner.
//
// Ports
//   clk, rst                 system clock, synchronous active-low reset
//   a_* / b_*                requester request channels (addr, wdata, rw,
//                            valid, ready) and response channels
//                            (res_data, res_valid)
//   addr_o, wdata_o, rw_o,   chain head request, registered
//   valid_o, rdata_o         (rdata_o is tied to zero)
//   rdata_i, valid_i         chain tail response, one beat per issued request
//   busy                     at least one transaction outstanding
//   err                      sticky: a beat arrived with nothing outstanding
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  a_rw,
  input  logic                  a_valid,
  output logic                  a_ready,
  output logic [DATA_WIDTH-1:0] a_res_data,
  output logic                  a_res_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic                  b_rw,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] b_res_data,
  output logic                  b_res_valid,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  valid_i,
  output logic                  busy,
  output logic                  err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // Requester IDs stored in the FIFO.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             id_fifo [MAX_OUTSTANDING];
  logic             last_grant;

  logic space;
  logic grant_a;
  logic grant_b;
  logic push;
  logic pop;
  logic empty_pop;
  logic head_id;

  // A returning beat frees its slot in the same cycle, so a full FIFO can
  // still accept a new request while it is being popped.
  always_comb begin
    space   = (count < CNT_MAX) || valid_i;
    grant_a = 1'b0;
    grant_b = 1'b0;
    // Grants are suppressed while reset is asserted; the edge would discard
    // them anyway and requesters must re-present afterwards.
    if (rst && space) begin
      if (a_valid && b_valid) begin
        grant_a = (last_grant == ID_B);
        grant_b = (last_grant == ID_A);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign push      = grant_a || grant_b;
  assign pop       = valid_i && (count != '0);
  assign empty_pop = valid_i && (count == '0);
  assign head_id   = id_fifo[rd_ptr];

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign rdata_o = '0;
  assign busy    = (count != '0);

  // ---- stage boundary: grant / response arrival -> registered outputs ----

  // Control state: pointers, occupancy, round-robin history, strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_grant  <= ID_B;
      err         <= 1'b0;
      valid_o     <= 1'b0;
      a_res_valid <= 1'b0;
      b_res_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        last_grant <= grant_b ? ID_B : ID_A;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (empty_pop) begin
        err <= 1'b1;
      end
      valid_o     <= push;
      a_res_valid <= pop && (head_id == ID_A);
      b_res_valid <= pop && (head_id == ID_B);
    end
  end

  // Owner tag of each issued request, consumed in issue order.
  always_ff @(posedge clk) begin
    if (push) begin
      id_fifo[wr_ptr] <= grant_b ? ID_B : ID_A;
    end
  end

  // Bus head and response data. Held between beats; the unselected
  // response port keeps its last value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_o     <= '0;
      wdata_o    <= '0;
      rw_o       <= 1'b0;
      a_res_data <= '0;
      b_res_data <= '0;
    end else begin
      if (grant_a) begin
        addr_o  <= a_addr;
        wdata_o <= a_wdata;
        rw_o    <= a_rw;
      end else if (grant_b) begin
        addr_o  <= b_addr;
        wdata_o <= b_wdata;
        rw_o    <= b_rw;
      end
      if (pop && (head_id == ID_A)) begin
        a_res_data <= rdata_i;
      end
      if (pop && (head_id == ID_B)) begin
        b_res_data <= rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. A behavioural register chain (fixed
// latency, echoes write data, returns memory contents on reads) closes the
// loop from the chain head back to the chain tail. Every accepted request
// pushes its expected owner/data/latency into a scoreboard; the response
// monitor pops and compares as responses appear.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int MAXO      = 8;
  localparam int CHAIN_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] a_addr, b_addr, addr_o;
  logic [DW-1:0] a_wdata, b_wdata, wdata_o, rdata_o, rdata_i;
  logic [DW-1:0] a_res_data, b_res_data;
  logic          a_rw, a_valid, a_ready, a_res_valid;
  logic          b_rw, b_valid, b_ready, b_res_valid;
  logic          rw_o, valid_o, valid_i, busy, err;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_rw       (a_rw),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_res_data (a_res_data),
    .a_res_valid(a_res_valid),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_rw       (b_rw),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_res_data (b_res_data),
    .b_res_valid(b_res_valid),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .rdata_o    (rdata_o),
    .rw_o       (rw_o),
    .valid_o    (valid_o),
    .rdata_i    (rdata_i),
    .valid_i    (valid_i),
    .busy       (busy),
    .err        (err)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
  } req_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        lat_chk;
    int          due;
  } exp_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } beat_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   chain_pending = 0;
  int   a_rdy_cnt = 0;
  logic chk_en = 1'b0;
  logic hold   = 1'b0;
  logic pulse  = 1'b0;
  logic lat_en = 1'b1;

  req_t        a_pend[$];
  req_t        b_pend[$];
  exp_t        sb[$];
  rsp_t        rlog[$];
  logic        grant_log[$];
  logic [15:0] ref_mem   [256];
  logic [15:0] chain_mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester driver: presents queued requests, holds them until ready,
  // records each acceptance in the scoreboard and checks the issued beat.
  initial begin : driver
    logic a_fire, b_fire, prev_fire;
    req_t r, prev_req;
    exp_t e;
    a_valid = 0; a_addr = 0; a_wdata = 0; a_rw = 0;
    b_valid = 0; b_addr = 0; b_wdata = 0; b_rw = 0;
    prev_fire = 0;
    prev_req  = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valid_o", 32'(valid_o), 32'(prev_fire));
        if (prev_fire) begin
          chk("addr_o", 32'(addr_o), 32'(prev_req.addr));
          chk("wdata_o", 32'(wdata_o), 32'(prev_req.wdata));
          chk("rw_o", 32'(rw_o), 32'(prev_req.rw));
        end
        if (!a_valid) chk("a_ready_without_valid", 32'(a_ready), 0);
        if (!b_valid) chk("b_ready_without_valid", 32'(b_ready), 0);
      end
      if (a_ready === 1'b1) a_rdy_cnt++;
      a_fire = (a_valid === 1'b1) && (a_ready === 1'b1);
      b_fire = (b_valid === 1'b1) && (b_ready === 1'b1);
      if (chk_en && a_valid && b_valid) chk("single_grant", 32'(a_fire && b_fire), 0);
      @(posedge clk); #1;
      prev_fire = a_fire || b_fire;
      if (a_fire || b_fire) begin
        r = a_fire ? a_pend.pop_front() : b_pend.pop_front();
        e.id      = b_fire && !a_fire;
        e.data    = r.rw ? r.wdata : ref_mem[r.addr[7:0]];
        e.lat_chk = lat_en;
        e.due     = cyc + CHAIN_LAT + 1;
        if (r.rw) ref_mem[r.addr[7:0]] = r.wdata;
        sb.push_back(e);
        grant_log.push_back(e.id);
        prev_req = r;
      end
      if (a_pend.size() > 0) begin
        a_valid = 1; a_addr = a_pend[0].addr; a_wdata = a_pend[0].wdata; a_rw = a_pend[0].rw;
      end else a_valid = 0;
      if (b_pend.size() > 0) begin
        b_valid = 1; b_addr = b_pend[0].addr; b_wdata = b_pend[0].wdata; b_rw = b_pend[0].rw;
      end else b_valid = 0;
    end
  end

  // Register chain model: CHAIN_LAT cycles from head beat to tail beat.
  // While hold is set, tail beats are released only on a pulse request.
  initial begin : chain
    beat_t bq[$];
    beat_t bt;
    valid_i = 0;
    rdata_i = 0;
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        bt.due = cyc + CHAIN_LAT;
        if (rw_o) begin
          chain_mem[addr_o[7:0]] = wdata_o;
          bt.data = wdata_o;
        end else begin
          bt.data = chain_mem[addr_o[7:0]];
        end
        bq.push_back(bt);
      end
      chain_pending = bq.size();
      @(posedge clk); #1;
      if (bq.size() > 0 && bq[0].due <= cyc && (!hold || pulse)) begin
        bt = bq.pop_front();
        valid_i = 1;
        rdata_i = bt.data;
        pulse   = 0;
      end else begin
        valid_i = 0;
      end
      chain_pending = bq.size();
    end
  end

  // Response monitor.
  initial begin : monitor
    exp_t        e;
    rsp_t        r;
    logic        rst_prev;
    logic [15:0] a_prev, b_prev;
    rst_prev = 0; a_prev = 0; b_prev = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (rst_prev && a_res_valid !== 1'b1) chk("a_res_data_hold", 32'(a_res_data), 32'(a_prev));
        if (rst_prev && b_res_valid !== 1'b1) chk("b_res_data_hold", 32'(b_res_data), 32'(b_prev));
        if (a_res_valid === 1'b1 || b_res_valid === 1'b1) begin
          chk("res_exclusive", 32'(a_res_valid && b_res_valid), 0);
          r.id   = b_res_valid;
          r.data = b_res_valid ? b_res_data : a_res_data;
          r.cyc  = cyc;
          rlog.push_back(r);
          chk("res_has_pending_request", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_owner", 32'(r.id), 32'(e.id));
            chk("res_data", 32'(r.data), 32'(e.data));
            if (e.lat_chk) chk("res_latency", r.cyc, e.due);
          end
        end
      end
      rst_prev = rst;
      a_prev   = a_res_data;
      b_prev   = b_res_data;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((a_pend.size() > 0 || b_pend.size() > 0 || a_valid || b_valid ||
            sb.size() > 0 || chain_pending > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 32'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    sb.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 16'(i);
      chain_mem[i] = 16'(i);
    end
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_addr_o", 32'(addr_o), 0);
    chk("rst_wdata_o", 32'(wdata_o), 0);
    chk("rst_rw_o", 32'(rw_o), 0);
    chk("rst_rdata_o", 32'(rdata_o), 0);
    chk("rst_a_res_valid", 32'(a_res_valid), 0);
    chk("rst_b_res_valid", 32'(b_res_valid), 0);
    chk("rst_a_res_data", 32'(a_res_data), 0);
    chk("rst_b_res_data", 32'(b_res_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1 rst = 1;
    chk_en = 1;

    // Single read from A
    @(negedge clk);
    rlog.delete(); grant_log.delete(); a_rdy_cnt = 0;
    a_pend.push_back('{16'h0001, 16'h0000, 1'b0});
    wait_idle(100);
    chk("single_a_ready_cycles", a_rdy_cnt, 1);
    chk("single_rsp_count", rlog.size(), 1);
    if (rlog.size() > 0) begin
      chk("single_owner", 32'(rlog[0].id), 0);
      chk("single_data", 32'(rlog[0].data), 32'h0001);
    end
    chk("single_err", 32'(err), 0);

    // Contention from the same cycle, A wins the first tie after reset
    do_reset();
    @(negedge clk);
    rlog.delete(); grant_log.delete();
    a_pend.push_back('{16'h0009, 16'h0000, 1'b0});
    b_pend.push_back('{16'h0012, 16'h0000, 1'b0});
    wait_idle(100);
    chk("cont_grants", grant_log.size(), 2);
    chk("cont_rsp_count", rlog.size(), 2);
    if (grant_log.size() == 2) begin
      chk("cont_first_grant", 32'(grant_log[0]), 0);
      chk("cont_second_grant", 32'(grant_log[1]), 1);
    end
    if (rlog.size() == 2) begin
      chk("cont_a_data", 32'(rlog[0].data), 32'h0009);
      chk("cont_b_data", 32'(rlog[1].data), 32'h0012);
      chk("cont_consecutive", rlog[1].cyc - rlog[0].cyc, 1);
    end

    // Fairness under continuous contention
    @(negedge clk);
    rlog.delete(); grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      a_pend.push_back('{16'(16'h0030 + i), 16'h0000, 1'b0});
      b_pend.push_back('{16'(16'h0040 + i), 16'h0000, 1'b0});
    end
    wait_idle(200);
    chk("fair_grants", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("fair_order", 32'(grant_log[i]), 32'(i % 2));
    n = 0;
    foreach (rlog[i]) if (rlog[i].id == 1'b0) n++;
    chk("fair_a_rsp", n, 4);
    chk("fair_b_rsp", rlog.size() - n, 4);

    // Full FIFO with the chain tail held off
    @(negedge clk);
    rlog.delete(); grant_log.delete();
    hold = 1; lat_en = 0;
    for (int i = 0; i < 10; i++)
      b_pend.push_back('{16'(16'h0050 + i), 16'h0000, 1'b0});
    n = 0;
    while (grant_log.size() < 8 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("full_reached_8", grant_log.size(), 8);
    repeat (3) begin
      @(negedge clk);
      chk("full_b_ready_low", 32'(b_ready), 0);
      chk("full_b_valid_held", 32'(b_valid), 1);
      chk("full_busy", 32'(busy), 1);
    end
    pulse = 1;
    @(negedge clk);
    chk("full_pulse_valid_i", 32'(valid_i), 1);
    chk("full_pop_frees_slot", 32'(b_ready), 1);
    @(negedge clk);
    chk("full_grants_after_pulse", grant_log.size(), 9);
    chk("full_count_unchanged", 32'(b_ready), 0);
    hold = 0;
    wait_idle(200);
    lat_en = 1;
    chk("full_total_grants", grant_log.size(), 10);
    chk("full_total_rsp", rlog.size(), 10);

    // Write then read back from B
    @(negedge clk);
    rlog.delete();
    b_pend.push_back('{16'h0014, 16'hBEEF, 1'b1});
    b_pend.push_back('{16'h0014, 16'h0000, 1'b0});
    wait_idle(100);
    chk("wr_rsp_count", rlog.size(), 2);
    if (rlog.size() == 2) begin
      chk("wr_owner0", 32'(rlog[0].id), 1);
      chk("wr_owner1", 32'(rlog[1].id), 1);
      chk("wr_readback", 32'(rlog[1].data), 32'hBEEF);
    end
    chk("pre_midrst_err", 32'(err), 0);

    // Reset while reads are in flight
    @(negedge clk);
    rlog.delete();
    for (int i = 1; i <= 3; i++)
      a_pend.push_back('{16'(i), 16'h0000, 1'b0});
    n = 0;
    while ((a_pend.size() > 0 || a_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_issued", 32'(n < 30), 1);
    do_reset();
    wait_idle(100);
    chk("midrst_no_rsp", rlog.size(), 0);
    chk("midrst_err", 32'(err), 1);
    chk("midrst_busy", 32'(busy), 0);

    // Next A read after the aborted flight
    @(negedge clk);
    rlog.delete();
    a_pend.push_back('{16'h0005, 16'h0000, 1'b0});
    wait_idle(100);
    chk("post_rsp_count", rlog.size(), 1);
    if (rlog.size() > 0) begin
      chk("post_owner", 32'(rlog[0].id), 0);
      chk("post_data", 32'(rlog[0].data), 32'h0005);
    end
    chk("post_err_sticky", 32'(err), 1);
    chk("post_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
